// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC sequencing, single-outstanding word fetch, fetch buffer.
// Optional IFETCH_PERF_CNT_EN adds fetchCount/stallCycles performance counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pcValue,
  output logic [31:0] pcNext,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  output logic [31:0] instrData,
  output logic [31:0] instrPc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] fetchCount,
  output logic [31:0] stallCycles,
`endif
  input  logic        instrReady
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  state_e          state_q, state_d;
  logic            drop_q, drop_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  ent_t            mem_q [FIFO_DEPTH];

  logic space;
  logic grant;
  logic push;
  logic pop;

  assign space   = count_q < CW'(FIFO_DEPTH);
  assign memReq  = (state_q == S_REQ) && space;
  assign memAddr = pcValue;
  assign grant   = memReq && memGnt;
  assign push    = (state_q == S_WAIT) && memRvalid
                   && !drop_q && !redirect;
  assign pop     = (count_q != '0) && instrReady && !redirect;

  assign instrValid = count_q != '0;
  assign instrPc    = mem_q[rd_q].pc;
  assign instrData  = mem_q[rd_q].data;

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    req_pc_d = req_pc_q;
    pcNext   = pcValue;
    unique case (state_q)
      S_BOOT: begin
        pcNext  = RESET_PC;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (grant) begin
          pcNext   = pcValue + 32'd4;
          req_pc_d = pcValue;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memRvalid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
    // A fetch still in flight after redirect returns stale data: mark it dropped.
    if (redirect) begin
      pcNext = redirectPc;
      if (grant || (state_q == S_WAIT && !memRvalid)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    if (redirect) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_BOOT;
      drop_q   <= 1'b0;
      req_pc_q <= '0;
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      if (push) begin
        mem_q[wr_q] <= '{pc: req_pc_q, data: memRdata};
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(push);
      stall_cnt_q <= stall_cnt_q
                     + 32'((state_q == S_REQ) && !space);
    end
  end

  assign fetchCount  = fetch_cnt_q;
  assign stallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: PC register, memory and decode models plus a
// stream scoreboard; directed scenarios followed by a randomized run.
module tb_ifetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcValue = '0;
  logic [31:0] pcNext;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt = 1'b0;
  logic        memRvalid = 1'b0;
  logic [31:0] memRdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        instrValid;
  logic [31:0] instrData;
  logic [31:0] instrPc;
  logic        instrReady = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCycles;
`endif

  ifetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .RST        (rst),
    .pcValue    (pcValue),
    .pcNext     (pcNext),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memGnt     (memGnt),
    .memRvalid  (memRvalid),
    .memRdata   (memRdata),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .instrValid (instrValid),
    .instrData  (instrData),
    .instrPc    (instrPc),
`ifdef IFETCH_PERF_CNT_EN
    .fetchCount (fetchCount),
    .stallCycles(stallCycles),
`endif
    .instrReady (instrReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [31:0] popped[$];
  logic [31:0] gaddr[$];
  logic [31:0] exp_fetch = RPC;
  logic [31:0] out_addr = '0;
  bit          outst = 1'b0;
  bit          live = 1'b0;
  int          lat_left = 0;
  int          fetch_exp = 0;
  int          stall_exp = 0;
  int          lat_fix = 1;
  bit          gnt_en = 1'b1;
  bit          gnt_rnd = 1'b0;
  bit          rdy_rnd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] getp(input int i);
    return (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] getg(input int i);
    return (i < gaddr.size()) ? gaddr[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: check outputs at negedge, advance models, drive inputs.
  task automatic step();
    logic g, pop, rv, rd;
    logic [31:0] a, nxt;
    @(negedge clk);
    g   = memReq & memGnt;
    a   = memAddr;
    rd  = redirect;
    rv  = memRvalid;
    pop = instrValid & instrReady & ~redirect;
    if (rst) begin
      chk("rst_memReq", 32'(memReq), 32'd0);
      chk("rst_instrValid", 32'(instrValid), 32'd0);
      chk("rst_pcNext", pcNext, RPC);
      chk("rst_instrData", instrData, 32'd0);
      chk("rst_instrPc", instrPc, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
      chk("rst_fetchCount", fetchCount, 32'd0);
      chk("rst_stallCycles", stallCycles, 32'd0);
`endif
      q.delete();
      live      = 1'b0;
      exp_fetch = RPC;
      fetch_exp = 0;
      stall_exp = 0;
      g         = 1'b0;
    end else begin
      chk("instrValid", 32'(instrValid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("instrPc", instrPc, q[0].pc);
        chk("instrData", instrData, q[0].data);
      end
      if (memReq) chk("memAddr", memAddr, pcValue);
      chk("one_outstanding", 32'(memReq & outst & live), 32'd0);
      chk("pcNext", pcNext,
          rd ? redirectPc : (g ? pcValue + 32'd4 : pcValue));
`ifdef IFETCH_PERF_CNT_EN
      chk("fetchCount", fetchCount, 32'(fetch_exp));
      chk("stallCycles", stallCycles, 32'(stall_exp));
`endif
      if (g) begin
        chk("fetch_pc", a, exp_fetch);
        gaddr.push_back(a);
      end
      if (q.size() == DEPTH && !outst) stall_exp++;
      if (pop && q.size() != 0) begin
        popped.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (rv && outst && live && !rd) begin
        q.push_back('{out_addr, memRdata});
        fetch_exp++;
      end
      if (rd) begin
        q.delete();
        live      = 1'b0;
        exp_fetch = redirectPc;
      end else if (g) begin
        exp_fetch = a + 32'd4;
      end
    end
    nxt = pcNext;
    @(posedge clk);
    #1;
    pcValue = nxt;
    if (rv) begin
      memRvalid = 1'b0;
      outst     = 1'b0;
    end
    if (g) begin
      outst    = 1'b1;
      out_addr = a;
      live     = !rd;
      lat_left = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end
    if (outst && !memRvalid) begin
      lat_left--;
      if (lat_left == 0) begin
        memRvalid = 1'b1;
        memRdata  = mem_word(out_addr);
      end
    end
    memGnt = gnt_en && !outst && (!gnt_rnd || $urandom_range(0, 3) != 0);
    if (rdy_rnd) instrReady = 1'($urandom_range(0, 1));
    redirect = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    popped.delete();
    gaddr.delete();
  endtask

  initial begin
    int pi;
    int gi;

    // In-order stream with always-granting, 1-cycle memory.
    gnt_en = 1'b1; gnt_rnd = 1'b0; lat_fix = 1;
    rdy_rnd = 1'b0; instrReady = 1'b1;
    do_reset(2);
    repeat (20) step();
    chk("s1_pc0", getp(0), 32'h0);
    chk("s1_pc1", getp(1), 32'h4);
    chk("s1_pc2", getp(2), 32'h8);
    chk("s1_pc3", getp(3), 32'hC);

    // Decode stalled: buffer fills, fetch stops, PC holds.
    instrReady = 1'b0;
    do_reset(2);
    for (int i = 0; i < 40 && !(q.size() == DEPTH && !outst); i++) step();
    chk("s2_full_reached", 32'(q.size()), 32'(DEPTH));
    repeat (10) step();
    #1;
    chk("s2_memReq_off", 32'(memReq), 32'd0);
    chk("s2_pcNext_hold", pcNext, 32'h8);
    chk("s2_head_pc", instrPc, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("s6_stallCycles", stallCycles, 32'd10);
    chk("s6_fetchCount", fetchCount, 32'd2);
`endif
    gi = gaddr.size();
    instrReady = 1'b1;
    repeat (10) step();
    chk("s2_first_pop", getp(0), 32'h0);
    chk("s2_resume_addr", getg(gi), 32'h8);

    // Redirect while waiting on the fetch of PC 8.
    lat_fix = 3;
    do_reset(2);
    for (int i = 0; i < 60 && !(outst && out_addr == 32'h8 && !memRvalid); i++)
      step();
    chk("s3_wait_pc8", 32'(outst && out_addr == 32'h8), 32'd1);
    pi = popped.size();
    gi = gaddr.size();
    redirect = 1'b1;
    redirectPc = 32'h0000_0100;
    step();
    #1;
    chk("s3_flushed", 32'(instrValid), 32'd0);
    repeat (15) step();
    chk("s3_next_addr", getg(gi), 32'h100);
    chk("s3_next_pc", getp(pi), 32'h100);

    // Address wrap at the top of the space.
    lat_fix = 1;
    pi = popped.size();
    redirect = 1'b1;
    redirectPc = 32'hFFFF_FFF8;
    step();
    repeat (20) step();
    chk("s4_pc_fff8", getp(pi), 32'hFFFF_FFF8);
    chk("s4_pc_fffc", getp(pi + 1), 32'hFFFF_FFFC);
    chk("s4_pc_wrap", getp(pi + 2), 32'h0);

    // Reset mid-fetch with the response arriving afterwards.
    lat_fix = 3;
    do_reset(2);
    for (int i = 0; i < 40 && !(outst && live && !memRvalid); i++) step();
    chk("s5_in_wait", 32'(outst && live), 32'd1);
    do_reset(1);
    repeat (15) step();
    chk("s5_restart_addr", getg(0), RPC);
    chk("s5_restart_pc", getp(0), RPC);

    // Randomized traffic, redirects and one mid-run reset.
    lat_fix = 0; gnt_rnd = 1'b1; rdy_rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(1);
      if ($urandom_range(0, 19) == 0) begin
        redirect = 1'b1;
        redirectPc = $urandom & 32'hFFFF_FFFC;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
